// File: rtl/fn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fn_ctrl_pkg
// Shared definitions for the game-over / "RESET?" prompt controller:
//   - CNT_W     : width of every frame counter in the controller
//   - cnt_t     : frame counter type
//   - state_t   : FSM state encoding (also exported on state_o for debug LEDs)
//   - sat_inc() : saturating increment so no counter ever wraps
// -----------------------------------------------------------------------------
package fn_ctrl_pkg;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_PLAY    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PROMPT  = 3'd2,
        ST_IDLE    = 3'd3,
        ST_RESTART = 3'd4
    } state_t;

    // Holds at all-ones instead of rolling over to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : cnt_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/rise_edge.sv
// -----------------------------------------------------------------------------
// rise_edge
// Rising-edge detector for an already synchronised level signal.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (previous-value register cleared to 0)
//   d     : synchronised level input
//   pulse : high for the single cycle in which d is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic prev;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/reset_prompt_ctrl.sv
// -----------------------------------------------------------------------------
// reset_prompt_ctrl
// After game over: freeze the playfield, ignore buttons for ARM_FRAMES frames,
// then show a blinking "RESET?" prompt. Yes restarts the game (one-cycle
// restart pulse); no or a TIMEOUT_FRAMES timeout parks in IDLE, from which yes
// still restarts.
// Parameters (all 1..1023):
//   ARM_FRAMES     : frames after game over during which buttons are ignored
//   BLINK_FRAMES   : frames per blink half-period of the prompt
//   TIMEOUT_FRAMES : frames of PROMPT with no answer before entering IDLE
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   frame_tick : one-cycle pulse per video frame
//   game_over  : level, high while the game is lost
//   btn_yes    : debounced, synchronised confirm button (level)
//   btn_no     : debounced, synchronised decline button (level)
//   prompt_en  : enable of the "RESET?" overlay
//   freeze     : holds fruit/blade motion while high
//   restart    : one-cycle pulse reinitialising game state
//   state_o    : current FSM state encoding
// -----------------------------------------------------------------------------
module reset_prompt_ctrl
    import fn_ctrl_pkg::*;
#(
    parameter int unsigned ARM_FRAMES     = 60,
    parameter int unsigned BLINK_FRAMES   = 30,
    parameter int unsigned TIMEOUT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic       btn_yes,
    input  logic       btn_no,
    output logic       prompt_en,
    output logic       freeze,
    output logic       restart,
    output logic [2:0] state_o
);

    localparam cnt_t ARM_LIM   = cnt_t'(ARM_FRAMES);
    localparam cnt_t BLINK_LIM = cnt_t'(BLINK_FRAMES);
    localparam cnt_t TO_LIM    = cnt_t'(TIMEOUT_FRAMES);

    logic go_rise;
    logic yes_rise;
    logic no_rise;

    rise_edge u_go_edge  (.clk(clk), .rst_n(rst_n), .d(game_over), .pulse(go_rise));
    rise_edge u_yes_edge (.clk(clk), .rst_n(rst_n), .d(btn_yes),   .pulse(yes_rise));
    rise_edge u_no_edge  (.clk(clk), .rst_n(rst_n), .d(btn_no),    .pulse(no_rise));

    state_t state_q, state_d;
    cnt_t   arm_cnt_q, arm_cnt_d;
    cnt_t   blink_cnt_q, blink_cnt_d;
    cnt_t   to_cnt_q, to_cnt_d;
    logic   phase_q, phase_d;
    cnt_t   blink_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLAY;
            arm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            to_cnt_q    <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            to_cnt_q    <= to_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        to_cnt_d    = to_cnt_q;
        phase_d     = phase_q;
        blink_inc   = sat_inc(blink_cnt_q);

        unique case (state_q)
            ST_PLAY: begin
                // Only a fresh edge arms; a level left high after restart does not.
                if (go_rise) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = '0;
                end
            end

            ST_ARM: begin
                // Count stops at the arm limit, which is all the exit test needs.
                if (frame_tick && (arm_cnt_q < ARM_LIM)) begin
                    arm_cnt_d = sat_inc(arm_cnt_q);
                end
                // A button still held from gameplay keeps us here until released.
                if ((arm_cnt_q >= ARM_LIM) && !btn_yes && !btn_no) begin
                    state_d     = ST_PROMPT;
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                    to_cnt_d    = '0;
                end
            end

            ST_PROMPT: begin
                if (frame_tick) begin
                    if (blink_inc >= BLINK_LIM) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_inc;
                    end
                    to_cnt_d = sat_inc(to_cnt_q);
                end
                if (yes_rise) begin
                    state_d = ST_RESTART;
                end else if (no_rise || (to_cnt_q >= TO_LIM)) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (yes_rise) begin
                    state_d = ST_RESTART;
                end
            end

            ST_RESTART: begin
                state_d = ST_PLAY;
            end

            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // Outputs decode registers only; none sees an input combinationally.
    assign state_o   = state_q;
    assign freeze    = (state_q != ST_PLAY);
    assign prompt_en = (state_q == ST_PROMPT) && phase_q;
    assign restart   = (state_q == ST_RESTART);

endmodule

// File: tb/tb_reset_prompt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reset_prompt_ctrl
// Directed scenarios followed by a randomized run, every cycle compared with a
// behavioural reference model of the prompt controller
// (ARM_FRAMES=3, BLINK_FRAMES=2, TIMEOUT_FRAMES=10).
// -----------------------------------------------------------------------------
module tb_reset_prompt_ctrl;

    localparam int ARM_F   = 3;
    localparam int BLINK_F = 2;
    localparam int TO_F    = 10;

    // Model state names, numbered as the controller reports them.
    localparam int M_PLAY    = 0;
    localparam int M_ARM     = 1;
    localparam int M_PROMPT  = 2;
    localparam int M_IDLE    = 3;
    localparam int M_RESTART = 4;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       game_over;
    logic       btn_yes;
    logic       btn_no;
    logic       prompt_en;
    logic       freeze;
    logic       restart;
    logic [2:0] state_o;

    int checks;
    int failures;

    // Reference model variables.
    int m_state;
    int m_frames_armed;
    int m_blink_frames;
    int m_prompt_frames;
    bit m_visible;
    bit m_last_go;
    bit m_last_yes;
    bit m_last_no;

    reset_prompt_ctrl #(
        .ARM_FRAMES    (ARM_F),
        .BLINK_FRAMES  (BLINK_F),
        .TIMEOUT_FRAMES(TO_F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .game_over (game_over),
        .btn_yes   (btn_yes),
        .btn_no    (btn_no),
        .prompt_en (prompt_en),
        .freeze    (freeze),
        .restart   (restart),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state         = M_PLAY;
        m_frames_armed  = 0;
        m_blink_frames  = 0;
        m_prompt_frames = 0;
        m_visible       = 1'b1;
        m_last_go       = 1'b0;
        m_last_yes      = 1'b0;
        m_last_no       = 1'b0;
    endtask

    // One clock edge of the controller's behaviour, from the inputs present at it.
    task automatic model_step();
        bit go_new, yes_new, no_new, ready;
        go_new  = game_over && !m_last_go;
        yes_new = btn_yes && !m_last_yes;
        no_new  = btn_no && !m_last_no;
        m_last_go  = game_over;
        m_last_yes = btn_yes;
        m_last_no  = btn_no;

        case (m_state)
            M_PLAY: begin
                if (go_new) begin
                    m_state        = M_ARM;
                    m_frames_armed = 0;
                end
            end
            M_ARM: begin
                ready = (m_frames_armed >= ARM_F) && !btn_yes && !btn_no;
                if (frame_tick && m_frames_armed < 1023) m_frames_armed++;
                if (ready) begin
                    m_state         = M_PROMPT;
                    m_blink_frames  = 0;
                    m_prompt_frames = 0;
                    m_visible       = 1'b1;
                end
            end
            M_PROMPT: begin
                int waited;
                waited = m_prompt_frames;
                if (frame_tick) begin
                    m_blink_frames++;
                    if (m_blink_frames == BLINK_F) begin
                        m_blink_frames = 0;
                        m_visible      = !m_visible;
                    end
                    if (m_prompt_frames < 1023) m_prompt_frames++;
                end
                if (yes_new)                      m_state = M_RESTART;
                else if (no_new || waited >= TO_F) m_state = M_IDLE;
            end
            M_IDLE: begin
                if (yes_new) m_state = M_RESTART;
            end
            default: m_state = M_PLAY;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"},   8'(state_o),   8'(m_state));
        check({tag, ".prompt"},  8'(prompt_en), 8'(m_state == M_PROMPT && m_visible));
        check({tag, ".freeze"},  8'(freeze),    8'(m_state != M_PLAY));
        check({tag, ".restart"}, 8'(restart),   8'(m_state == M_RESTART));
    endtask

    // Inputs change on the falling edge; outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset applied between edges takes effect at once.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".state"},   8'(state_o),   8'd0);
        check({tag, ".prompt"},  8'(prompt_en), 8'd0);
        check({tag, ".freeze"},  8'(freeze),    8'd0);
        check({tag, ".restart"}, 8'(restart),   8'd0);
        @(negedge clk);
        game_over = 1'b0;
        btn_yes   = 1'b0;
        btn_no    = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // New game-over edge, arm period, then into PROMPT.
    task automatic reach_prompt();
        game_over = 1'b0;
        cycle();
        game_over = 1'b1;
        cycle();
        check("arm.state", 8'(state_o), 8'd1);
        tick(ARM_F);
        cycle();
        check("prompt.state", 8'(state_o), 8'd2);
        check("prompt.visible", 8'(prompt_en), 8'd1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        game_over  = 1'b0;
        btn_yes    = 1'b0;
        btn_no     = 1'b0;
        model_reset();

        @(negedge clk);
        compare_all("reset");
        cycle();
        rst_n = 1'b1;
        cycle();

        // Arm, prompt, blink, yes -> one-cycle restart -> play.
        game_over = 1'b1;
        cycle();
        check("s1.arm", 8'(state_o), 8'd1);
        tick(ARM_F);
        check("s1.still_arm", 8'(state_o), 8'd1);
        cycle();
        check("s1.prompt", 8'(prompt_en), 8'd1);
        tick(BLINK_F);
        check("s1.blink_off", 8'(prompt_en), 8'd0);
        tick(BLINK_F);
        check("s1.blink_on", 8'(prompt_en), 8'd1);
        btn_yes = 1'b1;
        cycle();
        check("s1.restart", 8'(restart), 8'd1);
        cycle();
        check("s1.play_freeze", 8'(freeze), 8'd0);
        check("s1.one_pulse", 8'(restart), 8'd0);

        // game_over still high on return to play: no retrigger.
        idle_cycles(3);
        check("s5.no_retrigger", 8'(state_o), 8'd0);

        // Yes held through the arm period keeps ARM; release -> PROMPT.
        game_over = 1'b0;
        cycle();
        game_over = 1'b1;
        cycle();
        tick(5);
        check("s2.held_arm", 8'(state_o), 8'd1);
        check("s2.held_prompt", 8'(prompt_en), 8'd0);
        btn_yes = 1'b0;
        cycle();
        check("s2.release_prompt", 8'(state_o), 8'd2);
        check("s2.no_restart", 8'(restart), 8'd0);
        btn_no = 1'b1;
        cycle();
        check("s2.no_idle", 8'(state_o), 8'd3);
        btn_no = 1'b0;
        cycle();
        btn_no = 1'b1;
        cycle();
        check("s2.no_ignored", 8'(state_o), 8'd3);
        btn_no  = 1'b0;
        btn_yes = 1'b1;
        cycle();
        check("s2.idle_restart", 8'(restart), 8'd1);
        btn_yes = 1'b0;
        cycle();

        // Timeout -> IDLE; yes -> restart.
        reach_prompt();
        tick(TO_F);
        check("s3.before_timeout", 8'(state_o), 8'd2);
        cycle();
        check("s3.timeout_idle", 8'(state_o), 8'd3);
        check("s3.idle_prompt", 8'(prompt_en), 8'd0);
        btn_yes = 1'b1;
        cycle();
        check("s3.restart", 8'(restart), 8'd1);
        btn_yes = 1'b0;
        cycle();
        check("s3.play", 8'(state_o), 8'd0);

        // Yes and no together: yes wins.
        reach_prompt();
        btn_yes = 1'b1;
        btn_no  = 1'b1;
        cycle();
        check("s4.yes_wins", 8'(state_o), 8'd4);
        btn_yes = 1'b0;
        btn_no  = 1'b0;
        cycle();

        // Yes edge on the timeout cycle: yes wins.
        reach_prompt();
        tick(TO_F);
        btn_yes = 1'b1;
        cycle();
        check("s4.yes_over_timeout", 8'(state_o), 8'd4);
        btn_yes = 1'b0;
        cycle();

        // Reset during PROMPT and during RESTART.
        reach_prompt();
        pulse_reset("s6.rst_prompt");
        reach_prompt();
        btn_yes = 1'b1;
        cycle();
        check("s6.in_restart", 8'(restart), 8'd1);
        pulse_reset("s6.rst_restart");
        idle_cycles(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0)  btn_yes   = ~btn_yes;
            if ($urandom_range(0, 9) == 0)  btn_no    = ~btn_no;
            if ($urandom_range(0, 24) == 0) game_over = ~game_over;
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset("rnd.rst");
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
